// File: rtl/line_packet_packer.sv
// line_packet_packer: validates YCbCr 4:2:2 line packets and packs each pixel
// into a 29-bit FIFO word {x, y, Y, C}; bad packets are dropped and counted.
module line_packet_packer #(
    parameter int PIXELS = 640,
    parameter int LINES  = 720
) (
    input  logic        i_clk_125M,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_sop,
    input  logic        i_last,
    input  logic [7:0]  i_data,
    input  logic        i_fifo_full,
    output logic        o_fifo_wr,
    output logic [28:0] o_fifo_din,
    output logic [15:0] o_pkt_cnt,
    output logic [7:0]  o_err_cnt,
    output logic        o_busy
);
    localparam int PW = $clog2(PIXELS);
    typedef enum logic [2:0] {IDLE, HDR1, PAY_Y, PAY_C, DROP} state_t;
    state_t        state_q, state_d;
    logic [1:0]    x_q, x_d;
    logic [2:0]    yh_q, yh_d;
    logic          pad_q, pad_d;
    logic [7:0]    yl_q, yl_d, luma_q, luma_d;
    logic [PW-1:0] pix_q, pix_d;
    logic          wr_q, wr_d;
    logic [28:0]   din_q, din_d;
    logic [15:0]   pkt_q, pkt_d;
    logic [7:0]    err_q, err_d;
    logic          err_ev, good_ev;
    logic          last_pix;
    logic [10:0]   y_full;
    assign y_full   = {yh_q, i_data};
    assign last_pix = pix_q == PW'(PIXELS - 1);
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        yh_d    = yh_q;
        pad_d   = pad_q;
        yl_d    = yl_q;
        luma_d  = luma_q;
        pix_d   = pix_q;
        wr_d    = 1'b0;
        din_d   = din_q;
        err_ev  = 1'b0;
        good_ev = 1'b0;
        if (i_valid) begin
            // sop always restarts framing; a packet already in DROP was counted earlier
            if (i_sop) begin
                err_ev  = state_q inside {HDR1, PAY_Y, PAY_C};
                x_d     = i_data[7:6];
                pad_d   = |i_data[5:3];
                yh_d    = i_data[2:0];
                pix_d   = '0;
                state_d = HDR1;
            end else begin
                case (state_q)
                    HDR1: begin
                        yl_d = i_data;
                        if (i_last || pad_q || y_full >= 11'(LINES)) begin
                            err_ev  = 1'b1;
                            state_d = i_last ? IDLE : DROP;
                        end else begin
                            state_d = PAY_Y;
                        end
                    end
                    PAY_Y: begin
                        luma_d  = i_data;
                        err_ev  = i_last;
                        state_d = i_last ? IDLE : PAY_C;
                    end
                    PAY_C: begin
                        if (i_fifo_full) begin
                            err_ev  = 1'b1;
                            state_d = i_last ? IDLE : DROP;
                        end else begin
                            wr_d  = 1'b1;
                            din_d = {x_q, yh_q, yl_q, luma_q, i_data};
                            if (last_pix) begin
                                good_ev = i_last;
                                err_ev  = !i_last;
                                state_d = i_last ? IDLE : DROP;
                            end else begin
                                err_ev  = i_last;
                                pix_d   = pix_q + 1'b1;
                                state_d = i_last ? IDLE : PAY_Y;
                            end
                        end
                    end
                    DROP:    state_d = i_last ? IDLE : DROP;
                    default: state_d = state_q;
                endcase
            end
        end
        pkt_d = pkt_q + {15'd0, good_ev};
        err_d = err_q + {7'd0, err_ev && err_q != 8'hFF};
    end
    always_ff @(posedge i_clk_125M) begin
        if (i_rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            yh_q    <= '0;
            pad_q   <= 1'b0;
            yl_q    <= '0;
            luma_q  <= '0;
            pix_q   <= '0;
            wr_q    <= 1'b0;
            din_q   <= '0;
            pkt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            yh_q    <= yh_d;
            pad_q   <= pad_d;
            yl_q    <= yl_d;
            luma_q  <= luma_d;
            pix_q   <= pix_d;
            wr_q    <= wr_d;
            din_q   <= din_d;
            pkt_q   <= pkt_d;
            err_q   <= err_d;
        end
    end
    assign o_fifo_wr  = wr_q;
    assign o_fifo_din = din_q;
    assign o_pkt_cnt  = pkt_q;
    assign o_err_cnt  = err_q;
    assign o_busy     = state_q != IDLE;
endmodule
